// File: rtl/path_delay_pkg.sv
// path_delay_pkg: shared constants and the delay-selection helper for
// path_delay_sum.
//   DLY_W     width of the delay/remaining/age counters
//   AGE_MAX   saturation value of a slot age counter
//   sel_delay picks the path delay for an input change
package path_delay_pkg;

    localparam int DLY_W = 8;
    localparam logic [DLY_W-1:0] AGE_MAX = '1;

    // An a-change selects P1/P2 on the new a[0]. A b-only change selects PB.
    // When both change, the slower path wins.
    function automatic logic [DLY_W-1:0] sel_delay(
        input logic             a_chg,
        input logic             b_chg,
        input logic             a0,
        input logic [DLY_W-1:0] p1,
        input logic [DLY_W-1:0] p2,
        input logic [DLY_W-1:0] pb
    );
        logic [DLY_W-1:0] da;
        da = a0 ? p1 : p2;
        if (a_chg && b_chg)
            return (da > pb) ? da : pb;
        else if (a_chg)
            return da;
        else
            return pb;
    endfunction

endpackage

// File: rtl/path_delay_sum_slot.sv
// pd_slot: one pending-update slot of path_delay_sum.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   load              capture load_rem/load_val, age restarts at 0
//   load_rem          cycles remaining minus one until maturity
//   load_val          {carry, sum} carried by the event
//   flush             discard the slot contents
//   valid             slot occupied
//   mature            occupied and remaining==0; value is due on this edge
//   age               cycles since the load, saturating
//   value             stored {carry, sum}
module pd_slot
    import path_delay_pkg::*;
#(
    parameter int VAL_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DLY_W-1:0] load_rem,
    input  logic [VAL_W-1:0] load_val,
    input  logic             flush,
    output logic             valid,
    output logic             mature,
    output logic [DLY_W-1:0] age,
    output logic [VAL_W-1:0] value
);

    typedef struct packed {
        logic             valid;
        logic [DLY_W-1:0] remaining;
        logic [DLY_W-1:0] age;
        logic [VAL_W-1:0] value;
    } slot_t;

    slot_t s;

    assign valid  = s.valid;
    assign age    = s.age;
    assign value  = s.value;
    assign mature = s.valid && (s.remaining == '0);

    // A maturing slot frees on this edge; the top never loads a slot that is
    // still valid in transport mode, so reuse only happens a cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s <= '0;
        end else if (load) begin
            s.valid     <= 1'b1;
            s.remaining <= load_rem;
            s.age       <= '0;
            s.value     <= load_val;
        end else if (flush || mature) begin
            s.valid <= 1'b0;
        end else if (s.valid) begin
            s.remaining <= s.remaining - 1'b1;
            if (s.age != AGE_MAX)
                s.age <= s.age + 1'b1;
        end
    end

endmodule

// File: rtl/path_delay_sum.sv
// path_delay_sum: clocked conditional-path-delay adder. {x, y} = a + b, with
// each update applied P1/P2/PB cycles after the causing input change.
// Ports:
//   clk       sole clock, rising edge
//   reset     asynchronous, active-high
//   a, b      WIDTH-bit operands
//   clr_ovf   clears overflow (a same-cycle drop wins)
//   x, y      carry and low bits of the delayed sum
//   pending   number of occupied slots
//   overflow  sticky, an event was dropped because all slots were full
// Build option: PATH_DELAY_INERTIAL_EN selects inertial mode, where a new
// event cancels all outstanding ones; overflow then stays 0.
module path_delay_sum
    import path_delay_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int P1    = 10,
    parameter int P2    = 21,
    parameter int PB    = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       clr_ovf,
    output logic                       x,
    output logic [WIDTH-1:0]           y,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       overflow
);

    localparam int VAL_W = WIDTH + 1;
    localparam int PW    = $clog2(DEPTH + 1);
    localparam logic [DLY_W-1:0] P1_D = P1[DLY_W-1:0];
    localparam logic [DLY_W-1:0] P2_D = P2[DLY_W-1:0];
    localparam logic [DLY_W-1:0] PB_D = PB[DLY_W-1:0];

    logic [WIDTH-1:0] a_q, b_q;
    logic             a_chg, b_chg, ev;
    logic [DLY_W-1:0] ev_rem;
    logic [VAL_W-1:0] ev_val;

    logic [DEPTH-1:0] s_valid, s_mature, s_load;
    logic [DLY_W-1:0] s_age   [DEPTH];
    logic [VAL_W-1:0] s_value [DEPTH];
    logic             flush, drop;

    logic             any_mat;
    logic [DLY_W-1:0] win_age;
    logic [VAL_W-1:0] win_val;
    logic [PW-1:0]    nxt_cnt;

    assign a_chg  = (a != a_q);
    assign b_chg  = (b != b_q);
    assign ev     = a_chg || b_chg;
    assign ev_rem = sel_delay(a_chg, b_chg, a[0], P1_D, P2_D, PB_D) - 1'b1;
    assign ev_val = {1'b0, a} + {1'b0, b};

`ifdef PATH_DELAY_INERTIAL_EN
    assign flush = ev;

    // Every slot is cleared by the event, so slot 0 is always the free one.
    always_comb begin
        s_load    = '0;
        s_load[0] = ev;
        drop      = 1'b0;
    end
`else
    assign flush = 1'b0;

    // Lowest-index free slot takes the event; a slot maturing this cycle is
    // still valid here and therefore not offered.
    always_comb begin
        logic found;
        s_load = '0;
        found  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && !s_valid[i]) begin
                s_load[i] = ev;
                found     = 1'b1;
            end
        end
        drop = ev && !found;
    end
`endif

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_slot
            pd_slot #(.VAL_W(VAL_W)) u_slot (
                .clk      (clk),
                .reset    (reset),
                .load     (s_load[g]),
                .load_rem (ev_rem),
                .load_val (ev_val),
                .flush    (flush),
                .valid    (s_valid[g]),
                .mature   (s_mature[g]),
                .age      (s_age[g]),
                .value    (s_value[g])
            );
        end
    endgenerate

    // Youngest matured event wins; strict compare keeps the lowest index on
    // equal (including saturated) ages.
    always_comb begin
        any_mat = 1'b0;
        win_age = '1;
        win_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (s_mature[i] && (!any_mat || s_age[i] < win_age)) begin
                any_mat = 1'b1;
                win_age = s_age[i];
                win_val = s_value[i];
            end
        end
    end

    // Occupancy after this edge: newly loaded, or held and neither maturing
    // nor flushed.
    always_comb begin
        nxt_cnt = '0;
        for (int i = 0; i < DEPTH; i++)
            nxt_cnt = nxt_cnt +
                      PW'(s_load[i] || (s_valid[i] && !s_mature[i] && !flush));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            x        <= 1'b0;
            y        <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            a_q     <= a;
            b_q     <= b;
            pending <= nxt_cnt;
            if (any_mat)
                {x, y} <= win_val;
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_path_delay_sum.sv
// tb_path_delay_sum: scoreboard bench for path_delay_sum (transport build).
// A timeline model of scheduled updates predicts the post-edge outputs of
// every edge; a monitor compares them one time unit after each edge.
module tb_path_delay_sum;

    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int P1    = 10;
    localparam int P2    = 21;
    localparam int PB    = 12;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic         clr_ovf = 1'b0;
    logic [W-1:0] a       = '0;
    logic [W-1:0] b       = '0;
    logic         x;
    logic [W-1:0] y;
    logic [2:0]   pending;
    logic         overflow;

    always #5 clk = ~clk;

    path_delay_sum #(
        .WIDTH(W), .DEPTH(DEPTH), .P1(P1), .P2(P2), .PB(PB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .clr_ovf  (clr_ovf),
        .x        (x),
        .y        (y),
        .pending  (pending),
        .overflow (overflow)
    );

    typedef struct {
        int         due;
        int         born;
        logic [W:0] val;
    } ev_t;

    typedef struct {
        int         n;
        logic [W:0] xy;
        int         pend;
        logic       ovf;
    } exp_t;

    ev_t  evs[$];
    exp_t sb[$];

    logic [W-1:0] m_a   = '0;
    logic [W-1:0] m_b   = '0;
    logic [W:0]   m_xy  = '0;
    logic         m_ovf = 1'b0;

    int edge_cnt = 0;
    int checks   = 0;
    int errors   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input int n, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s edge %0d: got %0d, expected %0d", nm, n, act, req);
        end
    endtask

    // Predicts the outputs after edge n from the inputs presented for it.
    task automatic model_step(input int n);
        bit         ac, bc, drop;
        int         occ, best, d, da;
        logic [W:0] s;
        if (reset) begin
            evs.delete();
            m_a   = '0;
            m_b   = '0;
            m_xy  = '0;
            m_ovf = 1'b0;
        end else begin
            ac   = (a != m_a);
            bc   = (b != m_b);
            drop = 1'b0;
            occ  = evs.size();
            best = -1;
            foreach (evs[i])
                if (evs[i].due == n && (best < 0 || evs[i].born > evs[best].born))
                    best = i;
            if (best >= 0)
                m_xy = evs[best].val;
            for (int i = evs.size() - 1; i >= 0; i--)
                if (evs[i].due == n)
                    evs.delete(i);
            if (ac || bc) begin
                da = a[0] ? P1 : P2;
                if (ac && bc)
                    d = (da > PB) ? da : PB;
                else if (ac)
                    d = da;
                else
                    d = PB;
                s = {1'b0, a} + {1'b0, b};
                if (occ < DEPTH)
                    evs.push_back('{due: n + d, born: n, val: s});
                else
                    drop = 1'b1;
            end
            if (drop)
                m_ovf = 1'b1;
            else if (clr_ovf)
                m_ovf = 1'b0;
            m_a = a;
            m_b = b;
        end
        sb.push_back('{n: n, xy: m_xy, pend: evs.size(), ovf: m_ovf});
    endtask

    task automatic cyc(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic c, input logic r);
        @(posedge clk);
        #2;
        a       = av;
        b       = bv;
        clr_ovf = c;
        reset   = r;
        model_step(edge_cnt + 1);
    endtask

    task automatic seg(input int n, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic c, input logic r);
        repeat (n) cyc(av, bv, c, r);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].n < edge_cnt) begin
                e = sb.pop_front();
                chk("stale_entry", e.n, edge_cnt, e.n);
            end
            if (sb.size() > 0 && sb[0].n == edge_cnt) begin
                e = sb.pop_front();
                chk("x",        e.n, int'(x),        int'(e.xy[W]));
                chk("y",        e.n, int'(y),        int'(e.xy[W-1:0]));
                chk("pending",  e.n, int'(pending),  e.pend);
                chk("overflow", e.n, int'(overflow), int'(e.ovf));
            end
        end
    end

    // Stimulus
    initial begin
        logic [W-1:0] na, nb;
        logic         c, r;
        int           pch;

        seg(3, 0, 0, 0, 1);
        // P1 path
        seg(3, 0, 0, 0, 0);  seg(30, 3, 0, 0, 0);  seg(2, 3, 0, 0, 1);
        // P2 path
        seg(3, 0, 0, 0, 0);  seg(30, 2, 0, 0, 0);  seg(2, 0, 0, 0, 1);
        // PB path
        seg(3, 0, 0, 0, 0);  seg(20, 0, 5, 0, 0);  seg(2, 0, 0, 0, 1);
        // both change, carry out
        seg(3, 0, 0, 0, 0);  seg(20, 15, 1, 0, 0); seg(2, 0, 0, 0, 1);
        // overflow: five b changes, then clear
        seg(3, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) cyc(0, 4'(k), 0, 0);
        seg(20, 0, 5, 0, 0); cyc(0, 5, 1, 0); seg(10, 0, 5, 0, 0);
        // clear coinciding with a drop
        for (int k = 6; k <= 10; k++) cyc(0, 4'(k), 0, 0);
        cyc(0, 11, 1, 0); seg(25, 0, 11, 0, 0);
        seg(2, 0, 0, 0, 1);
        // simultaneous maturity: a-change (21) and b-change (12) due together
        seg(3, 0, 0, 0, 0);  seg(9, 2, 0, 0, 0);   seg(30, 2, 7, 0, 0);
        seg(2, 0, 0, 0, 1);
        // reset mid-operation with a held through reset
        seg(3, 0, 0, 0, 0);  seg(3, 1, 0, 0, 0);   seg(1, 1, 0, 0, 1);
        seg(15, 1, 0, 0, 0);

        // randomized phases of varying change density
        for (int blk = 0; blk < 15; blk++) begin
            case ($urandom_range(0, 2))
                0:       pch = 30;
                1:       pch = 8;
                default: pch = 2;
            endcase
            for (int k = 0; k < 200; k++) begin
                na = a;
                nb = b;
                if ($urandom_range(1, pch) == 1) begin
                    case ($urandom_range(0, 2))
                        0:       na = 4'($urandom);
                        1:       nb = 4'($urandom);
                        default: begin na = 4'($urandom); nb = 4'($urandom); end
                    endcase
                end
                r = ($urandom_range(0, 399) == 0);
                c = ($urandom_range(0, 24) == 0);
                cyc(na, nb, c, r);
            end
        end
        seg(30, a, b, 0, 0);

        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drained", edge_cnt, sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
